// File: rtl/dps_irq_collector_if.sv
// Bus request/return and interrupt handshake bundle for dps_irq_collector.
interface dps_irq_collector_if;
    logic        iDPS_REQ;
    logic        oDPS_BUSY;
    logic        iDPS_RW;
    logic [31:0] iDPS_ADDR;
    logic [31:0] iDPS_DATA;
    logic        oDPS_VALID;
    logic        iDPS_BUSY;
    logic [31:0] oDPS_DATA;
    logic        oDPS_IRQ_REQ;
    logic [5:0]  oDPS_IRQ_NUM;
    logic        iDPS_IRQ_ACK;

    modport slave (
        input  iDPS_REQ, iDPS_RW, iDPS_ADDR, iDPS_DATA, iDPS_BUSY, iDPS_IRQ_ACK,
        output oDPS_BUSY, oDPS_VALID, oDPS_DATA, oDPS_IRQ_REQ, oDPS_IRQ_NUM
    );

    modport master (
        output iDPS_REQ, iDPS_RW, iDPS_ADDR, iDPS_DATA, iDPS_BUSY, iDPS_IRQ_ACK,
        input  oDPS_BUSY, oDPS_VALID, oDPS_DATA, oDPS_IRQ_REQ, oDPS_IRQ_NUM
    );
endinterface

// File: rtl/dps_irq_collector.sv
// Four-source interrupt collector: pending/mask registers on a simple request bus,
// and a lowest-index-first IDLE/REQ/HOLD request FSM.
module dps_irq_collector #(
    parameter logic [3:0] P_INIT_MASK = 4'h0,
    parameter logic [3:0] P_EDGE_SEL  = 4'hF
) (
    input  logic                 iCLOCK,
    input  logic                 iRESET_SYNC,
    input  logic [3:0]           iSRC_IRQ,
    dps_irq_collector_if.slave   bus
);
    localparam int unsigned NSRC  = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned NUM_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              b_state;
    logic [NSRC-1:0]     b_pending;
    logic [NSRC-1:0]     b_mask;
    logic [NSRC-1:0]     b_src_q;
    logic [IDX_W-1:0]    b_irq_idx;
    logic                b_irq_req;
    logic [NUM_W-1:0]    b_irq_num;
    logic                b_valid;
    logic [DW-1:0]       b_data;

    logic                accept_c;
    logic                rd_c;
    logic                wr_c;
    logic                addr_ok_c;
    logic [1:0]          sel_c;
    logic [NSRC-1:0]     set_c;
    logic [NSRC-1:0]     w1c_c;
    logic [NSRC-1:0]     ack_clr_c;
    logic [NSRC-1:0]     active_c;
    logic [IDX_W-1:0]    low_idx_c;
    logic [DW-1:0]       rdata_c;
    logic                unused_ok;

    // Only one read may be outstanding, so the stall mirrors the response valid.
    assign accept_c  = bus.iDPS_REQ && !b_valid;
    assign rd_c      = accept_c && !bus.iDPS_RW;
    assign wr_c      = accept_c && bus.iDPS_RW;
    assign addr_ok_c = (bus.iDPS_ADDR[31:4] == 28'h0);
    assign sel_c     = bus.iDPS_ADDR[3:2];
    assign active_c  = b_pending & b_mask;
    assign unused_ok = ^{bus.iDPS_ADDR[1:0], bus.iDPS_DATA[31:4]};

    // Edge sources fire on a 0->1 transition; level sources re-set every cycle while high.
    always_comb begin
        set_c = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (P_EDGE_SEL[i]) set_c[i] = iSRC_IRQ[i] && !b_src_q[i];
            else               set_c[i] = iSRC_IRQ[i];
        end
    end

    always_comb begin
        w1c_c = '0;
        if (wr_c && addr_ok_c && (sel_c == 2'd0)) w1c_c = bus.iDPS_DATA[NSRC-1:0];
    end

    always_comb begin
        ack_clr_c = '0;
        if ((b_state == REQ) && bus.iDPS_IRQ_ACK) ack_clr_c[b_irq_idx] = 1'b1;
    end

    // Lowest set index wins arbitration.
    always_comb begin
        low_idx_c = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (active_c[i]) low_idx_c = IDX_W'(i);
        end
    end

    always_comb begin
        rdata_c = '0;
        if (addr_ok_c) begin
            case (sel_c)
                2'd0: rdata_c[NSRC-1:0] = b_pending;
                2'd1: rdata_c[NSRC-1:0] = b_mask;
                2'd2: begin
                    rdata_c[0]   = (b_state == REQ);
                    rdata_c[5:4] = b_irq_idx;
                end
                default: rdata_c = '0;
            endcase
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            b_state   <= IDLE;
            b_pending <= '0;
            b_mask    <= P_INIT_MASK;
            b_src_q   <= '0;
            b_irq_idx <= '0;
            b_irq_req <= 1'b0;
            b_irq_num <= '0;
            b_valid   <= 1'b0;
            b_data    <= '0;
        end else begin
            b_src_q   <= iSRC_IRQ;
            // A set in the same cycle as any clear takes priority.
            b_pending <= (b_pending & ~(w1c_c | ack_clr_c)) | set_c;
            if (wr_c && addr_ok_c && (sel_c == 2'd1)) b_mask <= bus.iDPS_DATA[NSRC-1:0];

            if (rd_c) begin
                b_valid <= 1'b1;
                b_data  <= rdata_c;
            end else if (b_valid && !bus.iDPS_BUSY) begin
                b_valid <= 1'b0;
                b_data  <= '0;
            end

            case (b_state)
                IDLE: begin
                    if (active_c != '0) begin
                        b_state   <= REQ;
                        b_irq_idx <= low_idx_c;
                        b_irq_req <= 1'b1;
                        b_irq_num <= {4'h0, low_idx_c};
                    end
                end
                REQ: begin
                    // Once latched, the request completes only through ack.
                    if (bus.iDPS_IRQ_ACK) begin
                        b_state   <= HOLD;
                        b_irq_req <= 1'b0;
                        b_irq_num <= '0;
                    end
                end
                HOLD: begin
                    b_state <= IDLE;
                end
                default: begin
                    b_state   <= IDLE;
                    b_irq_req <= 1'b0;
                    b_irq_num <= '0;
                end
            endcase
        end
    end

    assign bus.oDPS_BUSY    = b_valid;
    assign bus.oDPS_VALID   = b_valid;
    assign bus.oDPS_DATA    = b_data;
    assign bus.oDPS_IRQ_REQ = b_irq_req;
    assign bus.oDPS_IRQ_NUM = b_irq_num;
endmodule

// File: tb/tb_dps_irq_collector.sv
// Self-checking bench for dps_irq_collector: directed table, corner sequences,
// then randomized traffic against a behavioural model.
module tb_dps_irq_collector;
    localparam logic [3:0] P_INIT_MASK = 4'h8;
    localparam logic [3:0] P_EDGE_SEL  = 4'h5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] src = 4'h0;

    dps_irq_collector_if bus();

    dps_irq_collector #(.P_INIT_MASK(P_INIT_MASK), .P_EDGE_SEL(P_EDGE_SEL)) dut (
        .iCLOCK      (clk),
        .iRESET_SYNC (rst),
        .iSRC_IRQ    (src),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [3:0]  m_pend, m_mask, m_srcq;
    logic        m_req;
    int          m_idx;
    int          m_gap;
    logic        m_valid;
    logic [31:0] m_data;

    typedef struct {
        logic        rst, req, rw;
        logic [31:0] addr, wdata;
        logic        ibusy, ack;
        logic [3:0]  src;
        logic        xreq;
        logic [5:0]  xnum;
        logic        xvalid;
        logic [31:0] xdata;
    } vec_t;

    vec_t tbl[15];

    task automatic drive(input logic r, input logic rq, input logic rw, input logic [31:0] a,
                         input logic [31:0] d, input logic ib, input logic ak, input logic [3:0] s);
        rst              = r;
        bus.iDPS_REQ     = rq;
        bus.iDPS_RW      = rw;
        bus.iDPS_ADDR    = a;
        bus.iDPS_DATA    = d;
        bus.iDPS_BUSY    = ib;
        bus.iDPS_IRQ_ACK = ak;
        src              = s;
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        logic [31:0] v;
        v = 32'h0;
        if (a[31:4] == 28'h0) begin
            if (a[3:2] == 2'd0) v = {28'h0, m_pend};
            else if (a[3:2] == 2'd1) v = {28'h0, m_mask};
            else if (a[3:2] == 2'd2) v = 32'(m_idx * 16) + {31'h0, m_req};
        end
        return v;
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_edge();
        logic        acc;
        logic [3:0]  setv, clr, act;
        logic [31:0] rd;
        int          pick;
        if (rst) begin
            m_pend = 4'h0; m_mask = P_INIT_MASK; m_srcq = 4'h0;
            m_req = 1'b0; m_idx = 0; m_gap = 0; m_valid = 1'b0; m_data = 32'h0;
            return;
        end
        acc = bus.iDPS_REQ && !m_valid;
        for (int i = 0; i < 4; i++)
            setv[i] = P_EDGE_SEL[i] ? (src[i] && !m_srcq[i]) : src[i];
        clr = 4'h0;
        if (acc && bus.iDPS_RW && bus.iDPS_ADDR[31:4] == 28'h0 && bus.iDPS_ADDR[3:2] == 2'd0)
            clr = bus.iDPS_DATA[3:0];
        if (m_req && bus.iDPS_IRQ_ACK) clr[m_idx] = 1'b1;
        rd = model_rd(bus.iDPS_ADDR);

        if (m_req) begin
            if (bus.iDPS_IRQ_ACK) begin m_req = 1'b0; m_gap = 1; end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            act  = m_pend & m_mask;
            pick = -1;
            for (int i = 0; i < 4; i++) if (act[i] && pick < 0) pick = i;
            if (pick >= 0) begin m_req = 1'b1; m_idx = pick; end
        end

        if (acc && !bus.iDPS_RW) begin
            m_valid = 1'b1; m_data = rd;
        end else if (m_valid && !bus.iDPS_BUSY) begin
            m_valid = 1'b0; m_data = 32'h0;
        end

        if (acc && bus.iDPS_RW && bus.iDPS_ADDR[31:4] == 28'h0 && bus.iDPS_ADDR[3:2] == 2'd1)
            m_mask = bus.iDPS_DATA[3:0];
        m_pend = (m_pend & ~clr) | setv;
        m_srcq = src;
    endtask

    function automatic logic [40:0] dut_out();
        return {bus.oDPS_IRQ_REQ, bus.oDPS_IRQ_NUM, bus.oDPS_VALID, bus.oDPS_BUSY, bus.oDPS_DATA};
    endfunction

    function automatic logic [40:0] model_out();
        logic [5:0] num;
        num = m_req ? 6'(m_idx) : 6'h0;
        return {m_req, num, m_valid, m_valid, m_data};
    endfunction

    task automatic check(input string name, input logic [40:0] act, input logic [40:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (req,num,valid,busy,data)", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step(input string name);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check(name, dut_out(), model_out());
    endtask

    task automatic idle(input string name);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
        step(name);
    endtask

    task automatic wait_req(input string name, input logic [5:0] num, input int max);
        for (int i = 0; i < max && !bus.oDPS_IRQ_REQ; i++) idle(name);
        check_val(name, {25'h0, bus.oDPS_IRQ_REQ, bus.oDPS_IRQ_NUM}, {25'h0, 1'b1, num});
    endtask

    initial begin
        //         rst  req  rw   addr    wdata  ibsy ack  src    xreq xnum  xval xdata
        tbl[0]  = '{1, 0, 0, 32'h0,  32'h0, 0, 0, 4'h0, 0, 6'd0, 0, 32'h0};
        tbl[1]  = '{0, 1, 1, 32'h4,  32'hF, 0, 0, 4'h0, 0, 6'd0, 0, 32'h0};
        tbl[2]  = '{0, 0, 0, 32'h0,  32'h0, 0, 0, 4'h4, 0, 6'd0, 0, 32'h0};
        tbl[3]  = '{0, 1, 0, 32'h0,  32'h0, 0, 0, 4'h0, 1, 6'd2, 1, 32'h4};
        tbl[4]  = '{0, 0, 0, 32'h0,  32'h0, 0, 0, 4'h0, 1, 6'd2, 0, 32'h0};
        tbl[5]  = '{0, 0, 0, 32'h0,  32'h0, 0, 1, 4'h0, 0, 6'd0, 0, 32'h0};
        tbl[6]  = '{0, 1, 0, 32'h0,  32'h0, 0, 0, 4'h0, 0, 6'd0, 1, 32'h0};
        tbl[7]  = '{0, 0, 0, 32'h0,  32'h0, 0, 0, 4'h0, 0, 6'd0, 0, 32'h0};
        tbl[8]  = '{0, 1, 0, 32'h8,  32'h0, 0, 0, 4'h0, 0, 6'd0, 1, 32'h20};
        tbl[9]  = '{0, 1, 1, 32'h14, 32'h0, 0, 0, 4'h0, 0, 6'd0, 0, 32'h0};
        tbl[10] = '{0, 1, 0, 32'h7,  32'h0, 0, 0, 4'h0, 0, 6'd0, 1, 32'hF};
        tbl[11] = '{0, 1, 0, 32'h0,  32'h0, 1, 0, 4'h0, 0, 6'd0, 1, 32'hF};
        tbl[12] = '{0, 0, 0, 32'h0,  32'h0, 0, 0, 4'h0, 0, 6'd0, 0, 32'h0};
        tbl[13] = '{0, 1, 0, 32'hC,  32'h0, 0, 0, 4'h0, 0, 6'd0, 1, 32'h0};
        tbl[14] = '{0, 1, 0, 32'h10, 32'h0, 0, 0, 4'h0, 0, 6'd0, 0, 32'h0};

        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].rw, tbl[i].addr, tbl[i].wdata,
                  tbl[i].ibusy, tbl[i].ack, tbl[i].src);
            step("tbl_model");
            check($sformatf("tbl_row%0d", i), dut_out(),
                  {tbl[i].xreq, tbl[i].xnum, tbl[i].xvalid, tbl[i].xvalid, tbl[i].xdata});
        end

        // Simultaneous sources: lowest index first, then the other after HOLD.
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 4'hA); step("dual_pulse");
        wait_req("dual_first", 6'd1, 4);
        drive(0, 0, 0, 32'h0, 32'h0, 0, 1, 4'h0); step("dual_ack");
        check_val("dual_hold_low", {31'h0, bus.oDPS_IRQ_REQ}, 32'h0);
        idle("dual_idle");
        check_val("dual_idle_low", {31'h0, bus.oDPS_IRQ_REQ}, 32'h0);
        idle("dual_rearm");
        check_val("dual_second", {25'h0, bus.oDPS_IRQ_REQ, bus.oDPS_IRQ_NUM}, {25'h0, 1'b1, 6'd3});
        drive(0, 0, 0, 32'h0, 32'h0, 0, 1, 4'h0); step("dual_ack2");
        idle("dual_gap");

        // Masked pending, held read response, then unmask.
        drive(0, 1, 1, 32'h4, 32'h0, 0, 0, 4'h0); step("mask_off");
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 4'h1); step("mask_pulse");
        drive(0, 1, 0, 32'h0, 32'h0, 1, 0, 4'h0); step("hold_rd");
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 32'h4, 32'h0, 1, 0, 4'h0); step("hold_busy");
            check_val("hold_data", bus.oDPS_DATA, 32'h1);
            check_val("hold_noirq", {31'h0, bus.oDPS_IRQ_REQ}, 32'h0);
        end
        idle("hold_release");
        drive(0, 1, 1, 32'h4, 32'h1, 0, 0, 4'h0); step("mask_on");
        wait_req("unmask_req", 6'd0, 2);

        // New edge coinciding with ack keeps the bit pending and re-requests.
        drive(0, 0, 0, 32'h0, 32'h0, 0, 1, 4'h1); step("ack_edge");
        drive(0, 1, 0, 32'h0, 32'h0, 0, 0, 4'h0); step("ack_edge_rd");
        check_val("ack_edge_pend", bus.oDPS_DATA, 32'h1);
        wait_req("ack_edge_rereq", 6'd0, 3);
        drive(0, 0, 0, 32'h0, 32'h0, 0, 1, 4'h0); step("ack_clear");

        // Reset aborts an active request and an outstanding response.
        drive(0, 1, 1, 32'h4, 32'hF, 0, 0, 4'h0); step("rst_mask");
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 4'h4); step("rst_pulse");
        idle("rst_wait");
        drive(0, 1, 0, 32'h8, 32'h0, 1, 0, 4'h0); step("rst_rd");
        check_val("rst_pre", {30'h0, bus.oDPS_IRQ_REQ, bus.oDPS_VALID}, 32'h3);
        drive(1, 0, 0, 32'h0, 32'h0, 1, 1, 4'h0); step("rst_apply");
        check("rst_all_zero", dut_out(), 41'h0);
        drive(0, 1, 0, 32'h4, 32'h0, 0, 0, 4'h0); step("rst_mask_rd");
        check_val("rst_mask_val", bus.oDPS_DATA, {28'h0, P_INIT_MASK});

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a;
            a = {28'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) a[31:4] = 28'($urandom_range(1, 255));
            drive($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  a, $urandom, $urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dps_irq_collector.md
DPS_IRQ_COLLECTOR -- requirements
Module: dps_irq_collector

Interface
REQ-001 The block SHALL have parameter P_INIT_MASK, default 4'h0: reset value of MASK; a 1 bit enables that source.
REQ-002 The block SHALL have parameter P_EDGE_SEL, default 4'hF: per source, 1 = rising-edge capture, 0 = level.
REQ-003 The block SHALL have a single clock iCLOCK (in, 1) and a synchronous active-high reset iRESET_SYNC (in, 1); all state changes on the iCLOCK rising edge.
REQ-004 The block SHALL have these bus-request ports: iDPS_REQ (in, 1) request strobe; oDPS_BUSY (out, 1) request stall; iDPS_RW (in, 1) 0=read, 1=write; iDPS_ADDR (in, 32) byte address; iDPS_DATA (in, 32) write data.
REQ-005 The block SHALL have these bus-return ports: oDPS_VALID (out, 1) read data valid; iDPS_BUSY (in, 1) consumer stall; oDPS_DATA (out, 32) read data.
REQ-006 The block SHALL have these interrupt ports: oDPS_IRQ_REQ (out, 1) interrupt request; oDPS_IRQ_NUM (out, 6) interrupt number; iDPS_IRQ_ACK (in, 1) acknowledge.
REQ-007 The block SHALL have iSRC_IRQ (in, 4), the raw peripheral interrupt lines, synchronous to iCLOCK.

Function
REQ-008 A request SHALL be accepted on a cycle with iDPS_REQ=1 and oDPS_BUSY=0; it is ignored otherwise.
REQ-009 oDPS_BUSY SHALL equal oDPS_VALID, so at most one read response is outstanding.
REQ-010 The register map (iDPS_ADDR[3:2]) SHALL be: 0x0 PENDING (R, W1C [3:0]); 0x4 MASK (RW [3:0]); 0x8 STATUS (R: bit0 = FSM in REQ, bits[5:4] = latched index); 0xC reads 0. Unused bits read 0.
REQ-011 Addresses with iDPS_ADDR[31:4] != 0 SHALL read 0 and ignore writes; iDPS_ADDR[1:0] SHALL be ignored.
REQ-012 An accepted read at cycle N SHALL assert oDPS_VALID with registered oDPS_DATA at N+1. Both are held stable while iDPS_BUSY=1, and drop the cycle after a cycle with oDPS_VALID=1 and iDPS_BUSY=0.
REQ-013 Writes SHALL produce no response and take effect at the next edge.
REQ-014 An edge source (P_EDGE_SEL=1) SHALL set its PENDING bit when iSRC_IRQ is 1 and its previous-cycle registered value is 0.
REQ-015 A level source SHALL set PENDING every cycle its line is 1; a clear only takes effect once the line is 0.
REQ-016 PENDING bits SHALL be set regardless of MASK; MASK gates only request generation.
REQ-017 The IRQ FSM SHALL have three states: IDLE, REQ, HOLD.
REQ-018 In IDLE, if (PENDING & MASK) != 0, the FSM SHALL latch the lowest set index into b_irq_idx and enter REQ.
REQ-019 In REQ, oDPS_IRQ_REQ SHALL be 1 and oDPS_IRQ_NUM SHALL be {4'h0, b_irq_idx}.
REQ-020 In REQ, on iDPS_IRQ_ACK=1 the FSM SHALL clear PENDING[b_irq_idx] and enter HOLD; HOLD SHALL return to IDLE unconditionally after one cycle.
REQ-021 oDPS_IRQ_REQ SHALL be 0 in IDLE and HOLD, so minimum spacing between requests is 2 cycles of deassertion.
REQ-022 Masking or W1C-clearing the latched source while in REQ SHALL NOT retract the request; it completes on ack.
REQ-023 iDPS_IRQ_ACK SHALL be ignored outside REQ.
REQ-024 When a PENDING bit sees a set and a clear (ack or W1C) in the same cycle, the set SHALL win.
REQ-025 A W1C and an ack on different bits in the same cycle SHALL both take effect.
REQ-026 oDPS_IRQ_NUM SHALL read 0 when oDPS_IRQ_REQ=0.

Reset
REQ-027 iRESET_SYNC=1 SHALL force, at the next edge: PENDING=0, MASK=P_INIT_MASK, edge registers=0, FSM=IDLE, b_irq_idx=0, oDPS_VALID=0, oDPS_DATA=0. All outputs are therefore 0 after that edge.
REQ-028 Reset asserted mid-response or in REQ SHALL abort both with no ack or data completion; reset has priority over all other events.

Verification
REQ-029 Scenario: write MASK=0xF; pulse iSRC_IRQ[2] for 1 cycle -> PENDING=0x4 next cycle; oDPS_IRQ_REQ=1 with NUM=2 one cycle later; ack -> PENDING=0x0, REQ low for 2 cycles.
REQ-030 Scenario: iSRC_IRQ[1] and [3] rise in the same cycle, MASK=0xF -> NUM=1 first; after ack plus HOLD, NUM=3.
REQ-031 Scenario: read 0x0 with iDPS_BUSY=1 for 3 cycles -> oDPS_VALID/oDPS_DATA held 3 cycles; oDPS_BUSY=1 throughout; a second iDPS_REQ during that time is not accepted.
REQ-032 Scenario: MASK=0x0, pulse iSRC_IRQ[0] -> PENDING=0x1, no request; write MASK=0x1 -> request NUM=0 within 2 cycles.
REQ-033 Scenario: in REQ for idx 0, a new edge on iSRC_IRQ[0] coincides with ack -> PENDING[0] stays 1 and a second request NUM=0 follows HOLD.
REQ-034 Scenario: assert iRESET_SYNC while oDPS_IRQ_REQ=1 and oDPS_VALID=1 -> both 0 next edge; MASK reads back P_INIT_MASK.
